// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and operand packing for the
// sequential 4x4 matrix-product controller.
package matmul_pkg;

    localparam int N    = 4;
    localparam int EW   = 3;
    localparam int RW   = 8;
    localparam int IDXW = 2;
    localparam int CNTW = 5;
    localparam int KW   = 2 * IDXW;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN
    } state_t;

    // Element 0 lands in the least significant slot.
    function automatic logic [N*EW-1:0] pack4(
        input logic [EW-1:0] e0,
        input logic [EW-1:0] e1,
        input logic [EW-1:0] e2,
        input logic [EW-1:0] e3
    );
        return {e3, e2, e1, e0};
    endfunction

endpackage

// File: rtl/mm_operand_bank.sv
// Operand register file: A in entries 0-15, B in 16-31, both row-major.
// One write port, one A-row read and one B-column read.
module mm_operand_bank
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [CNTW-1:0]   addr,
    input  logic [EW-1:0]     data,
    input  logic [IDXW-1:0]   row,
    input  logic [IDXW-1:0]   col,
    output logic [N*EW-1:0]   row_a,
    output logic [N*EW-1:0]   col_b
);

    logic [EW-1:0] mem [2*N*N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[addr] <= data;
        end
    end

    assign row_a = pack4(mem[{1'b0, row, 2'd0}],
                         mem[{1'b0, row, 2'd1}],
                         mem[{1'b0, row, 2'd2}],
                         mem[{1'b0, row, 2'd3}]);

    assign col_b = pack4(mem[{1'b1, 2'd0, col}],
                         mem[{1'b1, 2'd1, col}],
                         mem[{1'b1, 2'd2, col}],
                         mem[{1'b1, 2'd3, col}]);

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Time-multiplexes one external 4-term MAC cell over a 4x4 product:
// serial operand load, one C element per cycle, tagged result stream.
module matmul_seq_ctrl
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EW-1:0]     in_data,
    output logic [N*EW-1:0]   mac_a,
    output logic [N*EW-1:0]   mac_b,
    input  logic [RW-1:0]     mac_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RW-1:0]     out_data,
    output logic [IDXW-1:0]   out_row,
    output logic [IDXW-1:0]   out_col,
    output logic              out_last,
    output logic              done
);

    state_t            state;
    state_t            state_nxt;
    logic [CNTW-1:0]   load_cnt;
    logic [KW-1:0]     k;
    logic [N*EW-1:0]   row_a;
    logic [N*EW-1:0]   col_b;
    logic              in_fire;
    logic              out_fire;
    logic              capture;
    logic              load_end;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign load_end = in_fire && (load_cnt == CNTW'(2*N*N-1));
    // A free output slot or a draining handshake both allow a new capture.
    assign capture  = (state == RUN) && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (load_end) state_nxt = RUN;
            RUN:     if (capture && k == KW'(N*N-1)) state_nxt = DRAIN;
            DRAIN:   if (out_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        mac_a    = '0;
        mac_b    = '0;
        unique case (state)
            IDLE: busy = 1'b0;
            LOAD: in_ready = 1'b1;
            RUN: begin
                mac_a = row_a;
                mac_b = col_b;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt <= '0;
            k        <= '0;
        end else if (abort) begin
            load_cnt <= '0;
            k        <= '0;
        end else begin
            if (state == IDLE && start) begin
                load_cnt <= '0;
            end else if (in_fire) begin
                load_cnt <= load_cnt + 1'b1;
            end
            if (load_end) begin
                k <= '0;
            end else if (capture) begin
                k <= k + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
        end else if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_data  <= mac_result;
            out_row   <= k[3:2];
            out_col   <= k[1:0];
            out_last  <= (k == KW'(N*N-1));
        end else if (state == DRAIN && out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= !abort && (state == DRAIN) && out_fire;
        end
    end

    mm_operand_bank u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (in_fire && !abort),
        .addr  (load_cnt),
        .data  (in_data),
        .row   (k[3:2]),
        .col   (k[1:0]),
        .row_a (row_a),
        .col_b (col_b)
    );

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench: table of uniform products, directed corner
// sequences, and randomized products against a plain matrix model.
module tb_matmul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_data = '0;
    logic [11:0] mac_a;
    logic [11:0] mac_b;
    logic [7:0]  mac_result;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        out_last;
    logic        done;

    int nerr = 0;
    int nchk = 0;
    int ma [16];
    int mb [16];
    int exp_c [16];
    int got;
    int first_cyc;
    int last_cyc;
    int bp_hold;

    typedef struct {
        int a;
        int b;
        int exp;
    } vec_t;

    vec_t tbl [5];

    always #5 clk = ~clk;

    matmul_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_result (mac_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last),
        .done       (done)
    );

    // External MAC cell: 4-term dot product.
    always_comb begin
        mac_result = '0;
        for (int j = 0; j < 4; j++) begin
            mac_result = mac_result
                       + 8'(mac_a[j*3 +: 3]) * 8'(mac_b[j*3 +: 3]);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic build_model();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                int s;
                s = 0;
                for (int t = 0; t < 4; t++) s += ma[i*4+t] * mb[t*4+j];
                exp_c[i*4+j] = s;
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) begin
            ma[i] = int'($urandom_range(0, 7));
            mb[i] = int'($urandom_range(0, 7));
        end
        build_model();
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // gap: 0 = always valid, 1 = toggle, 2 = random
    task automatic load_beats(input int n, input int gap, input int pulse_at);
        int idx;
        int cyc;
        logic acc;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 1000) begin
            @(negedge clk);
            if (gap == 0) in_valid = 1'b1;
            else if (gap == 1) in_valid = (cyc % 2 == 0);
            else in_valid = 1'($urandom_range(0, 1));
            in_data = 3'(idx < 16 ? ma[idx] : mb[idx-16]);
            start = (idx == pulse_at);
            acc = in_valid & in_ready;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            start = 1'b0;
            if (acc) idx++;
            cyc++;
        end
        check("load_beats", idx, n);
    endtask

    // mode: 0 = ready high, 1 = random ready + stray start, 2 = hold item 5
    task automatic collect(input int mode, input int nmax);
        int cyc;
        cyc = 0;
        got = 0;
        first_cyc = -1;
        last_cyc = -1;
        bp_hold = 0;
        while (got < nmax && cyc < 400) begin
            @(negedge clk);
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
            else out_ready = !(out_valid && got == 5 && bp_hold < 3);
            if (mode == 1) start = 1'($urandom_range(0, 1));
            if (mode == 2 && out_valid && !out_ready) begin
                bp_hold++;
                check("bp_row", int'(out_row), 1);
                check("bp_col", int'(out_col), 1);
                check("bp_data", int'(out_data), exp_c[5]);
            end
            if (out_valid && out_ready) begin
                check("res_data", int'(out_data), exp_c[got]);
                check("res_row", int'(out_row), got / 4);
                check("res_col", int'(out_col), got % 4);
                check("res_last", int'(out_last), int'(got == 15));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        check("res_count", got, nmax);
    endtask

    task automatic check_done();
        @(negedge clk);
        check("done_pulse", int'(done), 1);
        check("done_busy", int'(busy), 0);
        check("done_valid", int'(out_valid), 0);
        @(negedge clk);
        check("done_clear", int'(done), 0);
    endtask

    task automatic run_product(input int gap, input int pulse_at, input int omode);
        do_start();
        load_beats(32, gap, pulse_at);
        @(negedge clk);
        check("run_in_ready", int'(in_ready), 0);
        check("run_busy", int'(busy), 1);
        check("first_lat", int'(out_valid), 0);
        collect(omode, 16);
        check_done();
    endtask

    initial begin
        tbl[0] = '{a: 7, b: 7, exp: 196};
        tbl[1] = '{a: 1, b: 2, exp: 8};
        tbl[2] = '{a: 0, b: 5, exp: 0};
        tbl[3] = '{a: 3, b: 4, exp: 48};
        tbl[4] = '{a: 7, b: 1, exp: 28};

        #12;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_done", int'(done), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_row", int'(out_row), 0);
        check("rst_out_col", int'(out_col), 0);
        check("rst_mac_a", int'(mac_a), 0);
        check("rst_mac_b", int'(mac_b), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Uniform-operand table
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 16; i++) begin
                ma[i] = tbl[v].a;
                mb[i] = tbl[v].b;
                exp_c[i] = tbl[v].exp;
            end
            run_product(0, -1, 0);
        end

        // Identity times B[i][j] = (i+j)%8
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                ma[i*4+j] = (i == j) ? 1 : 0;
                mb[i*4+j] = (i + j) % 8;
                exp_c[i*4+j] = (i + j) % 8;
            end
        end
        run_product(0, -1, 0);
        check("ident_first_cyc", first_cyc, 0);
        check("ident_last_cyc", last_cyc, 15);

        // Backpressure on C[1][1]
        fill_random();
        run_product(0, -1, 2);
        check("bp_hold", bp_hold, 3);

        // Toggled in_valid with a stray start mid-load
        fill_random();
        run_product(1, 12, 0);

        // Abort after 10 beats, then a clean product
        for (int i = 0; i < 16; i++) begin
            ma[i] = 1;
            mb[i] = 2;
        end
        build_model();
        do_start();
        load_beats(10, 0, -1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        run_product(0, -1, 0);

        // start and abort together in IDLE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", int'(busy), 0);
        check("start_abort_ready", int'(in_ready), 0);

        // Randomized products
        for (int r = 0; r < 4; r++) begin
            fill_random();
            run_product(2, -1, 1);
        end

        // Async reset mid-RUN at k=7
        fill_random();
        do_start();
        load_beats(32, 0, -1);
        collect(0, 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_in_ready", int'(in_ready), 0);
        check("arst_out_data", int'(out_data), 0);
        check("arst_out_row", int'(out_row), 0);
        check("arst_out_col", int'(out_col), 0);
        check("arst_out_last", int'(out_last), 0);
        check("arst_mac_a", int'(mac_a), 0);
        check("arst_mac_b", int'(mac_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("post_rst_valid", int'(out_valid), 0);
            check("post_rst_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;

        fill_random();
        run_product(0, -1, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
Sequencer that time-multiplexes one 4-term multiply-accumulate cell across a full 4x4 matrix product. The multiplicands are 3-bit unsigned elements and each result is 8 bits.
- Loads A and B element-serially over a valid/ready stream into local registers.
- Drives the external mac cell with one row/column pair per cycle.
- Streams the 16 results out over a valid/ready stream with row/col tags.
- Sits between the host loader and the shared multiply-add datapath; this is the low-area alternative to the 16-cell parallel array.

Parameters:
N, 4, matrix dimension (fixed at 4; index widths derive from it)
EW, 3, element width in bits
RW, 8, result width in bits (4*7*7=196 fits)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  begin a new product; honoured only in IDLE
abort  in  1  synchronous cancel; returns to IDLE from any state
busy  out  1  high in any state other than IDLE
in_valid  in  1  operand element valid
in_ready  out  1  controller accepts an operand element
in_data  in  EW  operand element
mac_a  out  4*EW  {A[r][3],A[r][2],A[r][1],A[r][0]} to mac cell
mac_b  out  4*EW  {B[3][c],B[2][c],B[1][c],B[0][c]} to mac cell
mac_result  in  RW  combinational sum of products from mac cell
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  RW  C[r][c]
out_row  out  2  r of current result
out_col  out  2  c of current result
out_last  out  1  high with C[3][3]
done  out  1  one-cycle pulse after final result handshake

Behaviour:
- Reset (async, rst_n=0) forces the following:
  - state=IDLE; load_cnt=0; k=0.
  - in_ready=0, out_valid=0, out_last=0, done=0, busy=0.
  - out_data/out_row/out_col=0; mac_a/mac_b=0; operand bank contents=0.
  - Deasserting reset mid-operation resumes nothing; the block waits in IDLE for start.
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start=1 -> LOAD with load_cnt=0.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready beat writes element load_cnt. Beats 0-15 are A row-major (A[cnt[3:2]][cnt[1:0]]); beats 16-31 are B row-major.
  - Beat 31 -> RUN with k=0.
  - Gaps in in_valid are allowed; no timeout.
- RUN:
  - r=k[3:2] and c=k[1:0].
  - mac_a/mac_b are driven combinationally from the bank and k.
  - Capture condition is (out_valid==0 | out_ready). When it holds:
    - out_data<=mac_result, out_row<=r, out_col<=c, out_last<=(k==15), out_valid<=1.
    - k++ (4-bit wrap).
  - After the k==15 capture -> DRAIN.
- DRAIN:
  - Holds the last result.
  - On out_valid&out_ready: out_valid<=0, then IDLE.
  - done=1 for exactly the following cycle, with busy=0 in that cycle.
- Output stream rules:
  - While out_valid=1 and out_ready=0, out_* are held stable and k does not advance.
  - In RUN, a handshake and the next capture occur in the same cycle; with out_ready held high, the result stream is back-to-back.
- Latency:
  - First out_valid is 1 cycle after entering RUN.
  - With out_ready=1 throughout, results occupy 16 consecutive cycles; done is 17 cycles after RUN entry.
- start outside IDLE is ignored; busy stays high and contents are untouched.
- abort (priority over start and all transitions):
  - Next cycle: state=IDLE, out_valid=0, in_ready=0, load_cnt=0, k=0, no done.
  - Bank contents are kept but become stale; the next LOAD overwrites them.
- start and abort together in IDLE: abort wins and the block stays in IDLE.
- Arithmetic: the controller performs none; mac_result is passed through unmodified and unchecked.

Decomposition:
- Shared package matmul_pkg holds:
  - constants N, EW, RW, IDXW=2, CNTW=5;
  - state enum {IDLE, LOAD, RUN, DRAIN};
  - packing helper for 4-element operand vectors.
- Sub-module mm_operand_bank:
  - 32x EW register file, one write port (addr, data, we);
  - row-read mux (A[r][*]) and column-read mux (B[*][c]);
  - cleared only by rst_n.
- FSM, counters and the output register stay in matmul_seq_ctrl.

Test Plan:
- Identity: A=I, B[i][j]=(i+j)%8, out_ready=1 -> 16 results C[i][j]=(i+j)%8 in row-major order on consecutive cycles; out_last only on (3,3); done 1 cycle after the last handshake.
- Saturating values: all A and B elements=7 -> every out_data=196 (8'hC4); busy falls with done.
- Backpressure: out_ready=0 for 3 cycles while C[1][1] (k=5) is presented -> out_data/out_row/out_col held; no k advance; C[1][2] follows on release; no duplicate or dropped results.
- Load gaps: in_valid toggled 1/0 every cycle -> exactly 32 accepted beats; RUN entered after beat 31. start pulsed mid-LOAD -> load_cnt is not reset.
- Abort: abort after 10 LOAD beats -> next cycle in_ready=0, busy=0. A fresh start plus a full 32-beat load gives correct results (A=all 1, B=all 2 -> all 8).
- Async reset: rst_n=0 asserted mid-RUN at k=7 -> outputs go to reset values immediately, without waiting for a clock edge. After release there is no out_valid until a new start and load complete.
